multicycle_controller: RTL

//  Multicycle successor of the single-cycle ARM controller. A Moore FSM sequences one shared

---
 rtl/multicycle_controller.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle ARM controller FSM with multiply stall and long-multiply writeback
module multicycle_controller #(
    parameter int MUL_CYCLES = 3,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        Mul,
    output logic        AuxW
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTER,
        S_EXECUTEI, S_ALUWB, S_BRANCH, S_MULEX, S_MULWB, S_MULWB2
    } state_t;

    localparam logic [CNT_W-1:0] MCNT_LAST = CNT_W'(MUL_CYCLES - 1);

    state_t           state_q, state_d, st;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;

    logic [1:0] op;
    logic [5:0] funct;
    logic       is_mul, is_long, is_cmp, s_bit, rd_pc, cond_ex, cv_op;
    logic [3:0] dp_ctl, mul_ctl;
    logic       pc_w, mem_w, ir_w, reg_w;
    logic       unused_instr;

    assign op           = Instr[27:26];
    assign funct        = Instr[25:20];
    assign s_bit        = funct[0];
    assign is_cmp       = (funct[4:1] == 4'b1010);
    assign is_mul       = (op == 2'b00) && (funct[5:4] == 2'b00) && (Instr[7:4] == 4'b1001);
    assign is_long      = Instr[23];
    assign rd_pc        = (Instr[15:12] == 4'hF);
    assign cv_op        = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010) || is_cmp;
    assign mul_ctl      = !is_long ? 4'b0100 : (Instr[22] ? 4'b0110 : 4'b0101);
    assign unused_instr = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

    // Flags are NZCV: [3]=N [2]=Z [1]=C [0]=V
    always_comb begin
        cond_ex = 1'b1;
        case (Instr[31:28])
            4'h0: cond_ex = flags_q[2];
            4'h1: cond_ex = !flags_q[2];
            4'h2: cond_ex = flags_q[1];
            4'h3: cond_ex = !flags_q[1];
            4'h4: cond_ex = flags_q[3];
            4'h5: cond_ex = !flags_q[3];
            4'h6: cond_ex = flags_q[0];
            4'h7: cond_ex = !flags_q[0];
            4'h8: cond_ex = flags_q[1] && !flags_q[2];
            4'h9: cond_ex = !flags_q[1] || flags_q[2];
            4'hA: cond_ex = (flags_q[3] == flags_q[0]);
            4'hB: cond_ex = (flags_q[3] != flags_q[0]);
            4'hC: cond_ex = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'hD: cond_ex = flags_q[2] || (flags_q[3] != flags_q[0]);
            default: cond_ex = 1'b1;
        endcase
    end

    always_comb begin
        dp_ctl = 4'b0000;
        case (funct[4:1])
            4'b0100: dp_ctl = 4'b0000;
            4'b0010: dp_ctl = 4'b0001;
            4'b1010: dp_ctl = 4'b0001;
            4'b0000: dp_ctl = 4'b0010;
            4'b1100: dp_ctl = 4'b0011;
            default: dp_ctl = 4'b0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        mcnt_d  = mcnt_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (!cond_ex || op == 2'b11) state_d = S_FETCH;
                else if (op == 2'b01)        state_d = S_MEMADR;
                else if (op == 2'b10)        state_d = S_BRANCH;
                else if (is_mul)             state_d = S_MULEX;
                else if (funct[5])           state_d = S_EXECUTEI;
                else                         state_d = S_EXECUTER;
            end
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECUTER, S_EXECUTEI: begin
                state_d = is_cmp ? S_FETCH : S_ALUWB;
                if (s_bit || is_cmp) begin
                    flags_d[3:2] = ALUFlags[3:2];
                    if (cv_op) flags_d[1:0] = ALUFlags[1:0];
                end
            end
            S_MULEX: begin
                mcnt_d = mcnt_q + 1'b1;
                if (mcnt_q == MCNT_LAST) begin
                    mcnt_d  = '0;
                    state_d = S_MULWB;
                    if (s_bit) flags_d[3:2] = ALUFlags[3:2];
                end
            end
            S_MULWB:  state_d = is_long ? S_MULWB2 : S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // During reset the outputs show FETCH, with every write enable suppressed below
    always_comb begin
        st         = reset ? S_FETCH : state_q;
        pc_w       = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 4'b0000;
        Mul        = 1'b0;
        AuxW       = 1'b0;
        case (st)
            S_FETCH: begin
                ir_w = 1'b1; pc_w = 1'b1;
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                AdrSrc = 1'b1; ResultSrc = 2'b01; reg_w = 1'b1; pc_w = rd_pc;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1; mem_w = 1'b1;
            end
            S_EXECUTER: ALUControl = dp_ctl;
            S_EXECUTEI: begin
                ALUSrcB = 2'b01; ALUControl = dp_ctl;
            end
            S_ALUWB: begin
                reg_w = 1'b1; pc_w = rd_pc;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; pc_w = 1'b1;
            end
            S_MULEX: begin
                Mul = 1'b1; ALUControl = mul_ctl;
            end
            S_MULWB: begin
                Mul = 1'b1; ALUControl = mul_ctl; reg_w = 1'b1;
            end
            S_MULWB2: begin
                Mul = 1'b1; ALUControl = mul_ctl; reg_w = 1'b1; AuxW = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite  = pc_w && !reset;
    assign MemWrite = mem_w && !reset;
    assign IRWrite  = ir_w && !reset;
    assign RegWrite = reg_w && !reset;
    assign RegSrc   = {op == 2'b01, op == 2'b10};
    assign ImmSrc   = op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            mcnt_q  <= mcnt_d;
        end
    end
endmodule
